// File: rtl/output_buffer_drain_pkg.sv
// Shared definitions for the output buffer drain engine: lane width, word width and FSM encoding.
// MAC_OUTPUT_WIDTH is the global per-lane accumulator width shared with the conv core.
package output_buffer_drain_pkg;

    localparam int MAC_OUTPUT_WIDTH = 16;

    localparam int DRAIN_LANES  = 8;
    localparam int DRAIN_DATA_W = MAC_OUTPUT_WIDTH * DRAIN_LANES;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/output_buffer_drain_skid_fifo.sv
// drain_skid_fifo: synchronous FIFO absorbing reads already in flight when the drain output pauses.
// Occupancy is exported so the issuer can bound outstanding reads.
module output_buffer_drain_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             system_clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; occupancy alone defines which entries are live.
    always_ff @(posedge system_clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

    // The issuer bounds outstanding reads to DEPTH, so these can only fire on a design error.
    a_no_overflow: assert property (@(posedge system_clk) disable iff (!rst_n)
        !(push && !pop && count_q == CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge system_clk) disable iff (!rst_n)
        !(pop && count_q == '0));

endmodule

// File: rtl/output_buffer_drain.sv
// Output buffer read-out engine: streams a contiguous address burst to the activation path.
// Optional feature OUTBUF_CLEAR_ON_READ_EN zeroes each word as its read data returns.
module output_buffer_drain
    import output_buffer_drain_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2,
    parameter int SKID_DEPTH = 4
) (
    input  logic                    system_clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH:0]     burst_len,
    input  logic                    direct_out,
    input  logic                    pause,
    output logic                    ram_rd_en,
    output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
    input  logic [DRAIN_DATA_W-1:0] ram_rd_data,
    output logic [DRAIN_DATA_W-1:0] data_from_output_buffer,
    output logic                    data_from_output_buffer_valid,
    output logic                    busy,
    output logic                    done,
`ifdef OUTBUF_CLEAR_ON_READ_EN
    output logic                    ram_wr_en,
    output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
    output logic [DRAIN_DATA_W-1:0] ram_wr_data,
`endif
    output drain_state_t            state_dbg
);

    localparam int FIFO_CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W      = $clog2(SKID_DEPTH + RD_LATENCY + 1);

    drain_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     issued_q;
    logic                    zero_done_q;
    logic [RD_LATENCY-1:0]   lat_pipe_q;
    logic [DRAIN_DATA_W-1:0] out_data_q;
    logic                    out_valid_q;

    logic                    start_accept;
    logic                    zero_len_start;
    logic                    issue;
    logic                    last_issue;
    logic                    ret_valid;
    logic [OCC_W-1:0]        occupancy;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_empty;
    logic [FIFO_CNT_W-1:0]   fifo_count;
    logic [DRAIN_DATA_W-1:0] fifo_rd_data;
    logic                    bypass;

    assign start_accept   = (state_q == S_IDLE) && start && !direct_out && (burst_len != '0);
    assign zero_len_start = (state_q == S_IDLE) && start && !direct_out && (burst_len == '0);

    // Every read either sits in the FIFO or is still in the latency pipe, so bounding the
    // sum by SKID_DEPTH guarantees every returning word has a FIFO slot even when paused.
    assign occupancy  = OCC_W'(fifo_count) + OCC_W'($countones(lat_pipe_q));
    assign issue      = (state_q == S_READ) && !pause && (occupancy < OCC_W'(SKID_DEPTH));
    assign last_issue = issue && (issued_q == len_q - 1'b1);
    assign ret_valid  = lat_pipe_q[RD_LATENCY-1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_accept) state_d = S_READ;
            S_READ:  if (last_issue) state_d = S_DRAIN;
            S_DRAIN: if (fifo_empty && (lat_pipe_q == '0)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= zero_len_start;
            if (start_accept) begin
                base_q   <= base_addr;
                len_q    <= burst_len;
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + 1'b1;
            end
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_pipe_q <= '0;
        end else begin
            lat_pipe_q[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) lat_pipe_q[i] <= lat_pipe_q[i-1];
        end
    end

    // Returning data skips the FIFO when it is empty and the output is free, which gives the
    // RD_LATENCY+2 start-to-first-valid latency; otherwise it queues behind older words.
    assign fifo_pop  = !pause && !fifo_empty;
    assign bypass    = !pause && fifo_empty && ret_valid;
    assign fifo_push = ret_valid && !bypass;

    output_buffer_drain_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (DRAIN_DATA_W)
    ) u_drain_skid_fifo (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_data  (ram_rd_data),
        .pop        (fifo_pop),
        .pop_data   (fifo_rd_data),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (pause) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= fifo_pop || bypass;
            if (fifo_pop)    out_data_q <= fifo_rd_data;
            else if (bypass) out_data_q <= ram_rd_data;
        end
    end

`ifdef OUTBUF_CLEAR_ON_READ_EN
    logic [ADDR_WIDTH-1:0] wr_addr_pipe_q [RD_LATENCY];

    // Address travels alongside its latency bit so the clear lands the cycle data returns.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) wr_addr_pipe_q[i] <= '0;
        end else begin
            wr_addr_pipe_q[0] <= ram_rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) wr_addr_pipe_q[i] <= wr_addr_pipe_q[i-1];
        end
    end

    assign ram_wr_en   = ret_valid;
    assign ram_wr_addr = wr_addr_pipe_q[RD_LATENCY-1];
    assign ram_wr_data = '0;
`endif

    assign ram_rd_en                     = issue;
    assign ram_rd_addr                   = base_q + issued_q[ADDR_WIDTH-1:0];
    assign data_from_output_buffer       = out_data_q;
    assign data_from_output_buffer_valid = out_valid_q;
    assign busy                          = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done                          = (state_q == S_DONE) || zero_done_q;
    assign state_dbg                     = state_q;

endmodule
